// File: rtl/rr_priority_arbiter.sv
// Grant arbiter with fixed-priority or round-robin selection; one registered grant held until ack or request drop.
// Latency: 1 cycle from request to grant; a single idle bubble separates consecutive grants.
module rr_priority_arbiter #(
  parameter  int N  = 16,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          mode,
  input  logic          ack,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] idx_r, idx_nxt;
  logic [N-1:0]  gnt_r, gnt_nxt;
  logic          mode_r, mode_nxt;
  logic [IW-1:0] win_idx;
  logic          found;
  int            j;

  // Scan starts at ptr in round-robin mode and at 0 in fixed mode; wrap is mod N.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (mode ? int'(ptr) : 0) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        win_idx = IW'(j);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      idx_r  <= '0;
      gnt_r  <= '0;
      mode_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      idx_r  <= idx_nxt;
      gnt_r  <= gnt_nxt;
      mode_r <= mode_nxt;
    end
  end

  // mode is captured with the grant so a change mid-grant cannot alter the pointer update.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx_r;
    gnt_nxt   = gnt_r;
    mode_nxt  = mode_r;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          idx_nxt   = win_idx;
          gnt_nxt   = N'(1) << win_idx;
          mode_nxt  = mode;
        end
      end
      GRANT: begin
        if (ack || !req[idx_r]) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          gnt_nxt   = '0;
          if (mode_r)
            ptr_nxt = (idx_r == IW'(N - 1)) ? '0 : idx_r + IW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt       = gnt_r;
    gnt_idx   = idx_r;
    gnt_valid = (state == GRANT);
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Scoreboard bench: a behavioural model queues the expected outputs per cycle; DUT outputs are popped and compared after each edge.
module tb_rr_priority_arbiter;
  localparam int N  = 16;
  localparam int IW = $clog2(N);

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [IW-1:0] idx;
    logic          vld;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          mode = 1'b0;
  logic          ack = 1'b0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  // model state
  logic          m_busy = 1'b0;
  int            m_idx = 0;
  int            m_ptr = 0;
  logic          m_mode = 1'b0;

  rr_priority_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode), .ack(ack),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      m_busy = 1'b0; m_idx = 0; m_ptr = 0; m_mode = 1'b0;
    end else if (!m_busy) begin
      if (req != '0) begin
        w = -1;
        for (int k = 0; k < N && w < 0; k++)
          if (req[mode ? (m_ptr + k) % N : k]) w = mode ? (m_ptr + k) % N : k;
        m_busy = 1'b1; m_idx = w; m_mode = mode;
      end
    end else if (ack || !req[m_idx]) begin
      if (m_mode) m_ptr = (m_idx + 1) % N;
      m_busy = 1'b0; m_idx = 0;
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic md, input logic a);
    exp_t e, o;
    rst = r; req = rq; mode = md; ack = a;
    model_step();
    e.vld = m_busy;
    e.idx = m_busy ? IW'(m_idx) : '0;
    e.gnt = m_busy ? (N'(1) << m_idx) : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(1), 64'(0));
    end else begin
      o = sb.pop_front();
      chk("gnt", 64'(gnt), 64'(o.gnt));
      chk("gnt_idx", 64'(gnt_idx), 64'(o.idx));
      chk("gnt_valid", 64'(gnt_valid), 64'(o.vld));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r_req;
    logic         r_mode;

    // reset with all requests asserted
    step(1, 16'hFFFF, 0, 0);
    chk("rst_valid", 64'(gnt_valid), 64'(0));
    step(1, 16'hFFFF, 0, 0);
    chk("rst_gnt", 64'(gnt), 64'(0));

    // fixed priority: lowest set bit wins, re-grant after bubble
    step(0, 16'h8810, 0, 0);
    chk("fp_gnt", 64'(gnt), 64'h0010);
    chk("fp_idx", 64'(gnt_idx), 64'(4));
    step(0, 16'h8810, 0, 1);
    chk("fp_rel", 64'(gnt_valid), 64'(0));
    step(0, 16'h8810, 0, 0);
    chk("fp_regrant", 64'(gnt_idx), 64'(4));
    step(0, 16'h8810, 0, 1);

    // round-robin fairness: 0,4,0,4 with a bubble after each ack
    step(1, 16'h0000, 1, 0);
    for (int n = 0; n < 4; n++) begin
      step(0, 16'h0011, 1, 0);
      chk("rr_seq", 64'(gnt_idx), (n % 2 == 0) ? 64'(0) : 64'(4));
      step(0, 16'h0011, 1, 1);
      chk("rr_bubble", 64'(gnt_valid), 64'(0));
    end

    // wrap-around: drive ptr to 15 via a grant on 14, then 15 -> 0
    step(1, 16'h0000, 1, 0);
    step(0, 16'h4000, 1, 0);
    step(0, 16'h4000, 1, 1);
    step(0, 16'h8001, 1, 0);
    chk("wrap_15", 64'(gnt_idx), 64'(15));
    step(0, 16'h8001, 1, 1);
    step(0, 16'h8001, 1, 0);
    chk("wrap_0", 64'(gnt_idx), 64'(0));
    step(0, 16'h8001, 1, 1);

    // abandon: req[7] drops without ack, ptr moves to 8
    step(1, 16'h0000, 1, 0);
    step(0, 16'h0080, 1, 0);
    chk("ab_idx", 64'(gnt_idx), 64'(7));
    step(0, 16'h0000, 1, 0);
    chk("ab_drop", 64'(gnt_valid), 64'(0));
    step(0, 16'h0101, 1, 0);
    chk("ab_ptr8", 64'(gnt_idx), 64'(8));
    step(0, 16'h0101, 1, 1);

    // mode change during a grant must not alter it
    step(1, 16'h0000, 0, 0);
    step(0, 16'h0024, 0, 0);
    step(0, 16'h0024, 1, 0);
    chk("mode_hold", 64'(gnt_idx), 64'(2));
    step(0, 16'h0024, 1, 1);

    // no preemption, then reset mid-grant with no ptr update
    step(1, 16'h0000, 1, 0);
    step(0, 16'h0008, 1, 0);
    step(0, 16'h0009, 1, 0);
    chk("nopreempt", 64'(gnt_idx), 64'(3));
    step(1, 16'h0009, 1, 0);
    chk("midrst_valid", 64'(gnt_valid), 64'(0));
    step(0, 16'h0009, 1, 0);
    chk("midrst_ptr0", 64'(gnt_idx), 64'(0));
    step(0, 16'h0009, 1, 1);

    // randomised traffic against the model
    r_req = 16'h0000;
    r_mode = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) r_req = N'($urandom & $urandom);
      if ($urandom_range(7) == 0) r_mode = ~r_mode;
      step(($urandom_range(59) == 0), r_req, r_mode, ($urandom_range(3) == 0));
      chk("onehot", 64'($onehot0(gnt)), 64'(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_priority_arbiter.md
RR_PRIORITY_ARBITER -- requirements
Module: rr_priority_arbiter

Interface
REQ-001 SHALL provide parameter N, default 16, number of requesters (legal 2..64).
REQ-002 SHALL provide derived localparam IW, value $clog2(N), width of the grant index.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req, input, N, request vector; bit i is requester i.
REQ-006 SHALL have port mode, input, 1, arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-007 SHALL have port ack, input, 1, grantee done; releases the current grant.
REQ-008 SHALL have port gnt, output, N, registered one-hot grant vector.
REQ-009 SHALL have port gnt_idx, output, IW, registered binary index of the granted requester.
REQ-010 SHALL have port gnt_valid, output, 1, registered; high while a grant is held.

Function
REQ-011 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-012 IDLE, req == 0: SHALL stay in IDLE with gnt = 0, gnt_idx = 0, gnt_valid = 0.
REQ-013 IDLE, req != 0: SHALL select the winner combinationally, register it at the next edge, and enter GRANT. Latency is 1 cycle from the req edge to gnt_valid = 1.
REQ-014 Fixed mode: the winner SHALL be the lowest set index of req; pointer ptr is unused and unchanged.
REQ-015 Round-robin mode: the winner SHALL be the first set bit found scanning ptr, ptr+1, ... N-1, 0, ... ptr-1, with wrap-around.
REQ-016 mode SHALL be sampled only in IDLE; a mode change during GRANT SHALL NOT affect the held grant.
REQ-017 In GRANT, gnt, gnt_idx and gnt_valid SHALL hold stable, and requests on other bits SHALL NOT preempt the grant.
REQ-018 Release event = (ack == 1) OR (req[gnt_idx] == 0) while in GRANT.
- ack and a req drop in the same cycle count as one release.
REQ-019 On a release event, at the next edge the block SHALL:
- clear gnt, gnt_idx and gnt_valid;
- return to IDLE;
- in round-robin mode, set ptr = (gnt_idx + 1) mod N, so index N-1 wraps to 0.
REQ-020 The block SHALL leave one idle bubble cycle between consecutive grants.
REQ-021 ack in IDLE SHALL be ignored.
REQ-022 gnt SHALL always equal the one-hot decode of gnt_idx when gnt_valid = 1, and 0 otherwise; a multi-hot gnt is illegal.
REQ-023 For non-power-of-two N, ptr SHALL never reach a value of N or above, and the wrap SHALL be computed mod N, not mod 2^IW.

Reset
REQ-024 When rst = 1 at an edge, the block SHALL set state = IDLE, ptr = 0, gnt = 0, gnt_idx = 0 and gnt_valid = 0, regardless of state, req or ack.
REQ-025 Reset asserted mid-grant SHALL drop the grant at that edge with no ptr update.
REQ-026 The first grant after reset SHALL be evaluated as in REQ-013.

Verification
REQ-027 Reset: rst high 2 cycles with req = 16'hFFFF -> gnt = 0, gnt_valid = 0, gnt_idx = 0 throughout.
REQ-028 Fixed priority: mode = 0, req = 16'h8810 -> next cycle gnt = 16'h0010, gnt_idx = 4, gnt_valid = 1; ack pulse -> next cycle gnt_valid = 0; next grant again idx 4.
REQ-029 Round-robin fairness: mode = 1, req = 16'h0011 held, ack every grant -> grant sequence idx 0, 4, 0, 4 with one bubble between grants.
REQ-030 Wrap-around: mode = 1, req = 16'h8001, ptr = 15 -> grant idx 15; ack -> ptr = 0; next grant idx 0.
REQ-031 Abandon: grant on idx 7, req[7] drops with no ack -> next cycle gnt_valid = 0; round-robin ptr = 8.
REQ-032 Reset mid-grant and no preemption:
- grant idx 3 held; assert req[0] -> grant stays idx 3;
- rst pulse -> next edge all outputs 0, ptr = 0.
